// File: rtl/i2c_pkg.sv
// Shared types for the I2C bus monitor.
// Holds the decode FSM states and byte geometry.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ACK
  } i2c_mon_state_t;

  localparam int I2C_BYTE_BITS = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus persistence filter for one raw I2C pin.
// A new level must hold FILTER_CYCLES synced cycles before it is taken.
module i2c_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk100,
  input  logic reset,
  input  logic line_in,
  output logic line_f
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_o;

  assign sync_o = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      line_f <= 1'b1;
    end else if (sync_o == line_f) begin
      cnt    <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      cnt    <= '0;
      line_f <= ~line_f;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C front end: filtered lines, bus events,
// assembled bytes and the ACK bit, all in the clk100 domain.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 8
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     scl_f,
  output logic                     sda_f,
  output logic                     scl_rise,
  output logic                     scl_fall,
  output logic                     start_det,
  output logic                     stop_det,
  output logic                     bus_busy,
  output logic [I2C_BYTE_BITS-1:0] byte_data,
  output logic                     byte_valid,
  output logic                     ack_bit,
  output logic                     ack_valid
);

  logic scl_d, sda_d;
  logic rise_c, fall_c, start_c, stop_c;

  i2c_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_scl_filt (
    .clk100 (clk100),
    .reset  (reset),
    .line_in(scl_in),
    .line_f (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sda_filt (
    .clk100 (clk100),
    .reset  (reset),
    .line_in(sda_in),
    .line_f (sda_f)
  );

  // START/STOP need SCL high on both sides of the SDA edge
  assign rise_c  = scl_f & ~scl_d;
  assign fall_c  = ~scl_f & scl_d;
  assign start_c = scl_d & scl_f & sda_d & ~sda_f;
  assign stop_c  = scl_d & scl_f & ~sda_d & sda_f;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      scl_rise  <= rise_c;
      scl_fall  <= fall_c;
      start_det <= start_c;
      stop_det  <= stop_c;
      if (start_c) begin
        bus_busy <= 1'b1;
      end else if (stop_c) begin
        bus_busy <= 1'b0;
      end
    end
  end

  i2c_mon_state_t           state, state_nxt;
  logic [2:0]               bit_cnt, bit_cnt_nxt;
  logic [I2C_BYTE_BITS-1:0] shreg, shreg_nxt;
  logic [I2C_BYTE_BITS-1:0] byte_nxt;
  logic                     bv_nxt, ack_nxt, av_nxt;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      ack_bit    <= 1'b1;
      ack_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      byte_data  <= byte_nxt;
      byte_valid <= bv_nxt;
      ack_bit    <= ack_nxt;
      ack_valid  <= av_nxt;
    end
  end

  // start/stop imply steady-high SCL, so they never meet scl_rise
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    byte_nxt    = byte_data;
    bv_nxt      = 1'b0;
    ack_nxt     = ack_bit;
    av_nxt      = 1'b0;
    unique case (1'b1)
      start_det: begin
        state_nxt   = ST_DATA;
        bit_cnt_nxt = '0;
        shreg_nxt   = '0;
      end
      stop_det: begin
        state_nxt   = ST_IDLE;
        bit_cnt_nxt = '0;
        shreg_nxt   = '0;
      end
      scl_rise: begin
        if (state == ST_DATA) begin
          shreg_nxt   = {shreg[I2C_BYTE_BITS-2:0], sda_f};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'(I2C_BYTE_BITS - 1)) begin
            byte_nxt  = {shreg[I2C_BYTE_BITS-2:0], sda_f};
            bv_nxt    = 1'b1;
            state_nxt = ST_ACK;
          end
        end else if (state == ST_ACK) begin
          ack_nxt     = sda_f;
          av_nxt      = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = ST_DATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor with a cycle-indexed
// pin-history model compared against every output each cycle.
module tb_i2c_bus_monitor;

  localparam int S = 2;
  localparam int F = 8;
  localparam int H = 20;
  localparam int N = 16384;

  logic       clk100 = 1'b0;
  logic       reset  = 1'b1;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       scl_f, sda_f, scl_rise, scl_fall;
  logic       start_det, stop_det, bus_busy;
  logic [7:0] byte_data;
  logic       byte_valid, ack_bit, ack_valid;

  i2c_bus_monitor #(
    .SYNC_STAGES  (S),
    .FILTER_CYCLES(F)
  ) dut (
    .clk100    (clk100),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .ack_bit   (ack_bit),
    .ack_valid (ack_valid)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;
  int pe_cnt = 0;

  always @(posedge clk100) pe_cnt <= pe_cnt + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                 name, act, exp, pe_cnt);
    end
  endtask

  // p_*[i]: pin level sampled by posedge i; mf_*/e_*[k]: state after edge k
  bit p_scl [N];
  bit p_sda [N];
  bit mf_scl[N];
  bit mf_sda[N];
  bit e_rise[N];
  bit e_fall[N];
  bit e_start[N];
  bit e_stop[N];

  int         last_rst = 0;
  bit         m_busy, m_coll, m_await, m_ack, m_bv, m_av;
  int         m_nb;
  logic [7:0] m_bits, m_byte;

  int         n_start = 0, n_stop = 0, n_byte = 0, n_ack = 0;
  int         last_rise = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_ack = 1'b1;

  function automatic bit peff(bit sel, int idx);
    if (idx < 1 || idx <= last_rst) return 1'b1;
    return sel ? p_sda[idx] : p_scl[idx];
  endfunction

  // Filtered level flips once the synced pin has shown the other
  // level for F consecutive samples.
  function automatic bit filt_step(bit sel, int k);
    bit prev;
    prev = sel ? mf_sda[k-1] : mf_scl[k-1];
    for (int j = 0; j < F; j++)
      if (peff(sel, k - S - j) == prev) return prev;
    return !prev;
  endfunction

  always @(negedge clk100) begin
    int k;
    k = pe_cnt;
    if (k + 1 < N) begin
      p_scl[k+1] = scl_in;
      p_sda[k+1] = sda_in;
    end
    if (k < N) begin
      if (reset || k < 2) begin
        last_rst   = k + 1;
        mf_scl[k]  = 1'b1;
        mf_sda[k]  = 1'b1;
        e_rise[k]  = 1'b0;
        e_fall[k]  = 1'b0;
        e_start[k] = 1'b0;
        e_stop[k]  = 1'b0;
        m_busy  = 0; m_coll = 0; m_await = 0; m_nb = 0;
        m_bits  = 8'h00; m_byte = 8'h00; m_ack = 1;
        m_bv    = 0; m_av = 0;
      end else begin
        mf_scl[k]  = filt_step(1'b0, k);
        mf_sda[k]  = filt_step(1'b1, k);
        e_rise[k]  = mf_scl[k-1] & !mf_scl[k-2];
        e_fall[k]  = !mf_scl[k-1] & mf_scl[k-2];
        e_start[k] = mf_scl[k-1] & mf_scl[k-2] & !mf_sda[k-1] & mf_sda[k-2];
        e_stop[k]  = mf_scl[k-1] & mf_scl[k-2] & mf_sda[k-1] & !mf_sda[k-2];
        if (e_start[k]) m_busy = 1;
        else if (e_stop[k]) m_busy = 0;
        m_bv = 0;
        m_av = 0;
        if (e_start[k-1]) begin
          m_coll = 1; m_await = 0; m_nb = 0;
        end else if (e_stop[k-1]) begin
          m_coll = 0; m_await = 0; m_nb = 0;
        end else if (e_rise[k-1] && m_coll) begin
          if (m_await) begin
            m_ack = mf_sda[k-1]; m_av = 1; m_await = 0; m_nb = 0;
          end else begin
            m_bits = {m_bits[6:0], mf_sda[k-1]};
            m_nb++;
            if (m_nb == 8) begin
              m_byte = m_bits; m_bv = 1; m_await = 1; m_nb = 0;
            end
          end
        end
      end
      chk("scl_f",      scl_f,      mf_scl[k]);
      chk("sda_f",      sda_f,      mf_sda[k]);
      chk("scl_rise",   scl_rise,   e_rise[k]);
      chk("scl_fall",   scl_fall,   e_fall[k]);
      chk("start_det",  start_det,  e_start[k]);
      chk("stop_det",   stop_det,   e_stop[k]);
      chk("bus_busy",   bus_busy,   m_busy);
      chk("byte_data",  byte_data,  m_byte);
      chk("byte_valid", byte_valid, m_bv);
      chk("ack_bit",    ack_bit,    m_ack);
      chk("ack_valid",  ack_valid,  m_av);
    end
    if (start_det === 1'b1) n_start++;
    if (stop_det === 1'b1) n_stop++;
    if (scl_rise === 1'b1) last_rise = k;
    if (byte_valid === 1'b1) begin n_byte++; last_byte = byte_data; end
    if (ack_valid === 1'b1) begin n_ack++; last_ack = ack_bit; end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk100);
    #2;
  endtask

  task automatic do_start();
    if (!scl_in) begin
      sda_in = 1'b1; cyc(H);
      scl_in = 1'b1; cyc(H);
    end
    sda_in = 1'b0; cyc(H);
    scl_in = 1'b0; cyc(H);
  endtask

  task automatic send_bit(bit b);
    sda_in = b;    cyc(H);
    scl_in = 1'b1; cyc(H);
    scl_in = 1'b0; cyc(H);
  endtask

  task automatic send_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_stop();
    sda_in = 1'b0; cyc(H);
    scl_in = 1'b1; cyc(H);
    sda_in = 1'b1; cyc(H);
  endtask

  int s_start, s_stop, s_byte, s_ack, e_edge;

  task automatic snap();
    s_start = n_start; s_stop = n_stop;
    s_byte  = n_byte;  s_ack  = n_ack;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " scl_f"},     scl_f,     1);
    chk({tag, " sda_f"},     sda_f,     1);
    chk({tag, " bus_busy"},  bus_busy,  0);
    chk({tag, " byte_data"}, byte_data, 8'h00);
    chk({tag, " ack_bit"},   ack_bit,   1);
  endtask

  initial begin
    cyc(4);
    chk_reset_vals("por");
    reset = 1'b0;
    cyc(30);

    // glitch one cycle short of the filter length
    snap();
    sda_in = 1'b0; cyc(F - 1);
    sda_in = 1'b1; cyc(30);
    chk("t1 sda_f", sda_f, 1);
    chk("t1 starts", n_start - s_start, 0);

    // full byte with ACK
    snap();
    chk("t2 idle busy", bus_busy, 0);
    do_start();
    chk("t2 busy", bus_busy, 1);
    send_byte(8'hA5);
    send_bit(1'b0);
    do_stop();
    chk("t2 starts", n_start - s_start, 1);
    chk("t2 bytes", n_byte - s_byte, 1);
    chk("t2 byte", last_byte, 8'hA5);
    chk("t2 acks", n_ack - s_ack, 1);
    chk("t2 ack", last_ack, 0);
    chk("t2 stops", n_stop - s_stop, 1);
    chk("t2 end busy", bus_busy, 0);

    // repeated START after a partial byte
    snap();
    do_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    do_start();
    send_byte(8'h3C);
    send_bit(1'b0);
    chk("t3 starts", n_start - s_start, 2);
    chk("t3 bytes", n_byte - s_byte, 1);
    chk("t3 byte", last_byte, 8'h3C);
    chk("t3 busy", bus_busy, 1);
    do_stop();

    // STOP after 5 bits, then a clean byte
    snap();
    do_start();
    send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    do_stop();
    chk("t4 bytes", n_byte - s_byte, 0);
    chk("t4 acks", n_ack - s_ack, 0);
    snap();
    do_start();
    send_byte(8'h81);
    send_bit(1'b1);
    do_stop();
    chk("t4b bytes", n_byte - s_byte, 1);
    chk("t4b byte", last_byte, 8'h81);
    chk("t4b ack", last_ack, 1);

    // reset mid-byte
    do_start();
    send_bit(1); send_bit(0); send_bit(1);
    reset = 1'b1;
    sda_in = 1'b1;
    cyc(3);
    chk_reset_vals("t5");
    reset = 1'b0;
    cyc(2 * H);
    snap();
    do_start();
    send_byte(8'h7E);
    send_bit(1'b0);
    do_stop();
    chk("t5 bytes", n_byte - s_byte, 1);
    chk("t5 byte", last_byte, 8'h7E);

    // simultaneous SCL/SDA changes and edge latency
    snap();
    last_rise = 0;
    scl_in = 1'b0; sda_in = 1'b0; cyc(H);
    e_edge = pe_cnt;
    scl_in = 1'b1; sda_in = 1'b1; cyc(H);
    chk("t6 starts", n_start - s_start, 0);
    chk("t6 stops", n_stop - s_stop, 0);
    chk("t6 rise latency", last_rise - e_edge, S + F + 1);

    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
